fwd_hazard_ctrl: RTL

//  Parametrised forwarding + load-use hazard controller for the 5-stage core. Owns a shadow

---
 rtl/core_pkg.sv | 33 +++
 rtl/fwd_hazard_ctrl_if.sv | 28 ++
 rtl/fwd_hazard_ctrl_src_cmp.sv | 49 ++++
 rtl/fwd_hazard_ctrl.sv | 79 +++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the forwarding/hazard controller: EX operand select
// encodings and the shadow destination-pipeline slot layout.
package core_pkg;

    localparam int SEL_W = 2;
    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_RF  = 2'b00;
    localparam sel_t SEL_MEM = 2'b01;
    localparam sel_t SEL_WB  = 2'b10;

    // Slots carry register addresses zero-extended to the widest supported width.
    localparam int RA_W = 8;
    typedef logic [RA_W-1:0] raddr_t;

    typedef struct packed {
        logic   valid;
        raddr_t rdst;
        logic   wb;
        logic   load;
    } slot_t;

    function automatic slot_t make_slot(input logic valid, input raddr_t rdst,
                                        input logic wb, input logic load);
        slot_t s;
        s.valid = valid;
        s.rdst  = rdst;
        s.wb    = wb;
        s.load  = load;
        return s;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side bundle of the hazard controller: instruction info in, stall and
// EX operand selects out.
interface fwd_hazard_ctrl_if #(
    parameter int AW    = 3,
    parameter int NSRC  = 2,
    parameter int CNT_W = 16
);
    logic                flush;
    logic                id_valid;
    logic [NSRC*AW-1:0]  id_src;
    logic [NSRC-1:0]     id_src_used;
    logic [AW-1:0]       id_rdst;
    logic                id_wb;
    logic                id_load;
    logic                stall;
    logic [NSRC*2-1:0]   exec_sel;
    logic [CNT_W-1:0]    stall_cnt;

    modport master (
        output flush, id_valid, id_src, id_src_used, id_rdst, id_wb, id_load,
        input  stall, exec_sel, stall_cnt
    );

    modport slave (
        input  flush, id_valid, id_src, id_src_used, id_rdst, id_wb, id_load,
        output stall, exec_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl_src_cmp.sv
// Per-operand comparator: matches one decode source against the EX/MEM/WB
// slots and picks the bypass source for it.
module fwd_src_cmp
    import core_pkg::*;
#(
    parameter bit FWD_EN   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic   used_i,
    input  raddr_t src_i,
    input  slot_t  ex_i,
    input  slot_t  mem_i,
    input  slot_t  wb_i,
    output logic   raw_o,
    output logic   ld_hit_o,
    output sel_t   sel_o
);

    function automatic logic slot_match(input logic used, input raddr_t src, input slot_t s);
        return used & s.valid & s.wb & (src == s.rdst) & ~(ZERO_REG && (s.rdst == '0));
    endfunction

    logic m_ex;
    logic m_mem;
    logic m_wb;
    logic unused_load_bits;

    assign m_ex  = slot_match(used_i, src_i, ex_i);
    assign m_mem = slot_match(used_i, src_i, mem_i);
    assign m_wb  = slot_match(used_i, src_i, wb_i);

    // Only the EX slot's load flag matters: older loads already have data.
    assign unused_load_bits = mem_i.load ^ wb_i.load;

    assign raw_o    = m_ex | m_mem | m_wb;
    assign ld_hit_o = m_ex & ex_i.load;

    always_comb begin
        sel_o = SEL_RF;
        if (FWD_EN) begin
            if (m_ex && !ex_i.load) begin
                sel_o = SEL_MEM;
            end else if (m_mem) begin
                sel_o = SEL_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: shadow EX/MEM/WB destination
// pipeline, registered EX operand selects, decode stall and stall counter.
module fwd_hazard_ctrl
    import core_pkg::*;
#(
    parameter int AW       = 3,
    parameter int NSRC     = 2,
    parameter bit FWD_EN   = 1'b1,
    parameter bit ZERO_REG = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_ctrl_if.slave bus
);

    slot_t ex_q, mem_q, wb_q;
    slot_t ex_d;

    logic [NSRC-1:0]   raw;
    logic [NSRC-1:0]   ld_hit;
    logic [NSRC*2-1:0] exec_sel_d, exec_sel_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              stall_w;
    logic              advance;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            sel_t sel_nx;

            fwd_src_cmp #(
                .FWD_EN   (FWD_EN),
                .ZERO_REG (ZERO_REG)
            ) u_cmp (
                .used_i   (bus.id_src_used[gi]),
                .src_i    (raddr_t'(bus.id_src[gi*AW +: AW])),
                .ex_i     (ex_q),
                .mem_i    (mem_q),
                .wb_i     (wb_q),
                .raw_o    (raw[gi]),
                .ld_hit_o (ld_hit[gi]),
                .sel_o    (sel_nx)
            );

            // A held or squashed instruction leaves a bubble in EX, which reads the regfile.
            assign exec_sel_d[gi*2 +: 2] = advance ? sel_nx : SEL_RF;
        end
    endgenerate

    // With bypassing only an EX-stage load blocks; without it any in-flight writer does.
    assign stall_w = bus.id_valid & ~bus.flush & (FWD_EN ? |ld_hit : |raw);
    assign advance = bus.id_valid & ~stall_w & ~bus.flush;

    assign ex_d  = advance ? make_slot(1'b1, raddr_t'(bus.id_rdst), bus.id_wb, bus.id_load)
                           : '0;
    assign cnt_d = (stall_w && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            exec_sel_q <= '0;
            cnt_q      <= '0;
        end else begin
            ex_q       <= ex_d;
            mem_q      <= ex_q;
            wb_q       <= mem_q;
            exec_sel_q <= exec_sel_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.stall     = stall_w;
    assign bus.exec_sel  = exec_sel_q;
    assign bus.stall_cnt = cnt_q;

endmodule
